mc_controller: RTL and testbench

- Multicycle control unit for the RV32I core, with an optional M extension.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM/MDU and WB states.
- Waits on instruction-memory, data-memory and multiply/divide-unit handshakes.
- Registers decoded control fields in DECODE and holds them stable until the instruction retires.
- Traps on illegal opcodes and on memory-handshake timeouts.

---
 rtl/mc_controller_if.sv | 40 ++++
 rtl/mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Controller bus bundle: instruction/data/MDU handshakes plus the decoded control outputs.
interface mc_controller_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        mdu_done;
    logic        imem_req;
    logic        ir_wen;
    logic        pc_wen;
    logic        dmem_req;
    logic        mem_wen;
    logic [2:0]  byte_mask;
    logic        reg_wen;
    logic        alu_pc_sel;
    logic        alu_imm_sel;
    logic [3:0]  alu_ctrl;
    logic [2:0]  branch_cond;
    logic [1:0]  wb_sel;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        illegal_op;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    // Controller side
    modport slave (
        input  instr, imem_ready, dmem_ready, mdu_done,
        output imem_req, ir_wen, pc_wen, dmem_req, mem_wen, byte_mask, reg_wen,
               alu_pc_sel, alu_imm_sel, alu_ctrl, branch_cond, wb_sel,
               mdu_start, mdu_op, illegal_op, trap_cause, state
    );

    // Datapath / memory side
    modport master (
        output instr, imem_ready, dmem_ready, mdu_done,
        input  imem_req, ir_wen, pc_wen, dmem_req, mem_wen, byte_mask, reg_wen,
               alu_pc_sel, alu_imm_sel, alu_ctrl, branch_cond, wb_sel,
               mdu_start, mdu_op, illegal_op, trap_cause, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I(+M) control unit: FETCH/DECODE/EXEC/MEM/MDU/WB sequencer with
// registered control fields and illegal-opcode / bus-timeout traps.
module mc_controller #(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_controller_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_MDU   = 3'd5, S_WB     = 3'd6, S_TRAP = 3'd7
    } state_t;

    // Routing class of the instruction held in the control register
    typedef enum logic [2:0] {K_ALU, K_BR, K_LD, K_ST, K_MDU} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic       pc_sel;
        logic       imm_sel;
        logic [3:0] alu;
        logic [2:0] br;
        logic [2:0] bmask;
        logic [1:0] wb;
        logic [2:0] mop;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{kind: K_ALU, pc_sel: 1'b0, imm_sel: 1'b0, alu: 4'b0000,
                                   br: 3'b010, bmask: 3'b010, wb: 2'd0, mop: 3'd0};
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic [1:0]  r_cause;
    logic [15:0] r_cnt;
    logic        r_mdu_first;

    ctrl_t       w_dec;
    logic        w_illegal;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_to_hit;
    logic        w_unused;

    assign w_opc    = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_f7     = bus.instr[31:25];
    assign w_unused = ^{bus.instr[24:15], bus.instr[11:7]};
    // Current wait cycle is the last one allowed; a ready on this cycle still wins
    assign w_to_hit = (MEM_TIMEOUT != 0) && (r_cnt == TO_LAST);

    // Instruction decode into a candidate control word (latched only in DECODE)
    always_comb begin
        w_dec     = CTRL_RST;
        w_illegal = 1'b0;
        case (w_opc)
            7'b0110011: begin
                if (w_f7 == 7'b0000001) begin
                    if (ENABLE_M) begin
                        w_dec.kind = K_MDU;
                        w_dec.mop  = w_f3;
                        w_dec.wb   = 2'd3;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    w_dec.alu = {w_f3, w_f7[5]};
                end
            end
            7'b0010011: begin
                w_dec.imm_sel = 1'b1;
                w_dec.alu     = (w_f3 == 3'b101) ? {w_f3, w_f7[5]} : {w_f3, 1'b0};
            end
            7'b0000011, 7'b0100011: begin
                w_dec.kind    = (w_opc[5]) ? K_ST : K_LD;
                w_dec.imm_sel = 1'b1;
                w_dec.wb      = (w_opc[5]) ? 2'd0 : 2'd1;
                // Reserved width codes fall back to a word access
                w_dec.bmask   = (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) ? 3'b010 : w_f3;
            end
            7'b1100011: begin
                w_dec.kind    = K_BR;
                w_dec.pc_sel  = 1'b1;
                w_dec.imm_sel = 1'b1;
                w_dec.br      = (w_f3[2:1] == 2'b01) ? 3'b010 : w_f3;
            end
            7'b1101111: begin
                w_dec.pc_sel  = 1'b1;
                w_dec.imm_sel = 1'b1;
                w_dec.br      = 3'b011;
                w_dec.wb      = 2'd2;
            end
            7'b1100111: begin
                w_dec.imm_sel = 1'b1;
                w_dec.alu     = 4'b0011;
                w_dec.br      = 3'b011;
                w_dec.wb      = 2'd2;
            end
            7'b0110111: begin
                w_dec.imm_sel = 1'b1;
                w_dec.alu     = 4'b1111;
            end
            7'b0010111: begin
                w_dec.pc_sel  = 1'b1;
                w_dec.imm_sel = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Main sequencer: state, control register, trap cause and handshake timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ctrl      <= CTRL_RST;
            r_cause     <= 2'd0;
            r_cnt       <= 16'd0;
            r_mdu_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_DECODE;
                    end else if (w_to_hit) begin
                        r_cnt   <= 16'd0;
                        r_cause <= 2'd2;
                        r_state <= S_TRAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    r_ctrl <= w_dec;
                    if (w_illegal) begin
                        r_cause <= 2'd1;
                        r_state <= S_TRAP;
                    end else if (w_dec.kind == K_MDU) begin
                        r_mdu_first <= 1'b1;
                        r_state     <= S_MDU;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_ctrl.kind)
                        K_BR:       r_state <= S_FETCH;
                        K_LD, K_ST: r_state <= S_MEM;
                        default:    r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        r_cnt   <= 16'd0;
                        r_state <= (r_ctrl.kind == K_ST) ? S_FETCH : S_WB;
                    end else if (w_to_hit) begin
                        r_cnt   <= 16'd0;
                        r_cause <= 2'd2;
                        r_state <= S_TRAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_MDU: begin
                    r_mdu_first <= 1'b0;
                    if (bus.mdu_done) r_state <= S_WB;
                end
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.ir_wen      = (r_state == S_FETCH) && bus.imem_ready;
    assign bus.dmem_req    = (r_state == S_MEM);
    assign bus.mem_wen     = (r_state == S_MEM) && (r_ctrl.kind == K_ST);
    assign bus.reg_wen     = (r_state == S_WB);
    assign bus.pc_wen      = (r_state == S_WB)
                           || ((r_state == S_EXEC) && (r_ctrl.kind == K_BR))
                           || ((r_state == S_MEM) && (r_ctrl.kind == K_ST) && bus.dmem_ready);
    assign bus.mdu_start   = (r_state == S_MDU) && r_mdu_first;
    assign bus.illegal_op  = (r_state == S_TRAP) && (r_cause == 2'd1);
    assign bus.trap_cause  = r_cause;
    assign bus.state       = r_state;
    assign bus.byte_mask   = r_ctrl.bmask;
    assign bus.alu_pc_sel  = r_ctrl.pc_sel;
    assign bus.alu_imm_sel = r_ctrl.imm_sel;
    assign bus.alu_ctrl    = r_ctrl.alu;
    assign bus.branch_cond = r_ctrl.br;
    assign bus.wb_sel      = r_ctrl.wb;
    assign bus.mdu_op      = r_ctrl.mop;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one M-enabled instance walks the instruction
// sequences, a second instance with the M extension disabled must trap on MUL.
module tb_mc_controller;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_SB  = 32'h00308023;
    localparam logic [31:0] I_BNE = 32'h00209463;
    localparam logic [31:0] I_MUL = 32'h022081B3;
    localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

    mc_controller_if u_if ();
    mc_controller_if u_if0 ();

    mc_controller #(.ENABLE_M(1'b1), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    mc_controller #(.ENABLE_M(1'b0), .MEM_TIMEOUT(15)) dut_nom (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Starts in FETCH; leaves the DUT in DECODE
    task automatic do_fetch(input logic [31:0] ins, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("imem_req_wait", 32'(u_if.imem_req), 1);
            chk("ir_wen_wait", 32'(u_if.ir_wen), 0);
            cyc();
        end
        u_if.imem_ready = 1'b1;
        u_if.instr      = ins;
        #1;
        chk("imem_req_rdy", 32'(u_if.imem_req), 1);
        chk("ir_wen_rdy", 32'(u_if.ir_wen), 1);
        cyc();
        u_if.imem_ready = 1'b0;
        #1;
        chk("decode_state", 32'(u_if.state), 2);
        chk("decode_ir_wen", 32'(u_if.ir_wen), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        u_if.instr = 32'h0;  u_if.imem_ready = 1'b0;  u_if.dmem_ready = 1'b0;  u_if.mdu_done = 1'b0;
        u_if0.instr = I_MUL; u_if0.imem_ready = 1'b1; u_if0.dmem_ready = 1'b0; u_if0.mdu_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        // reset values
        chk("rst_state", 32'(u_if.state), 0);
        chk("rst_imem_req", 32'(u_if.imem_req), 0);
        chk("rst_pc_wen", 32'(u_if.pc_wen), 0);
        chk("rst_alu_ctrl", 32'(u_if.alu_ctrl), 0);
        chk("rst_branch_cond", 32'(u_if.branch_cond), 3'b010);
        chk("rst_byte_mask", 32'(u_if.byte_mask), 3'b010);
        chk("rst_wb_sel", 32'(u_if.wb_sel), 0);
        chk("rst_trap_cause", 32'(u_if.trap_cause), 0);
        cyc();
        chk("rst_hold_state", 32'(u_if.state), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_to_fetch", 32'(u_if.state), 1);

        // ADD with two imem wait cycles
        do_fetch(I_ADD, 2);
        cyc();
        chk("add_exec", 32'(u_if.state), 3);
        chk("add_exec_pc_wen", 32'(u_if.pc_wen), 0);
        chk("add_alu_imm_sel", 32'(u_if.alu_imm_sel), 0);
        cyc();
        chk("add_wb", 32'(u_if.state), 6);
        chk("add_reg_wen", 32'(u_if.reg_wen), 1);
        chk("add_pc_wen", 32'(u_if.pc_wen), 1);
        chk("add_alu_ctrl", 32'(u_if.alu_ctrl), 4'b0000);
        chk("add_wb_sel", 32'(u_if.wb_sel), 0);
        cyc();
        chk("add_back_fetch", 32'(u_if.state), 1);
        chk("add_reg_wen_off", 32'(u_if.reg_wen), 0);

        // M disabled instance has had ample cycles to reach its trap
        chk("nom_state", 32'(u_if0.state), 7);
        chk("nom_illegal_op", 32'(u_if0.illegal_op), 1);
        chk("nom_trap_cause", 32'(u_if0.trap_cause), 1);
        chk("nom_imem_req", 32'(u_if0.imem_req), 0);

        // LW with three dmem wait cycles
        do_fetch(I_LW, 0);
        cyc();
        chk("lw_exec", 32'(u_if.state), 3);
        chk("lw_byte_mask", 32'(u_if.byte_mask), 3'b010);
        chk("lw_wb_sel", 32'(u_if.wb_sel), 1);
        chk("lw_imm_sel", 32'(u_if.alu_imm_sel), 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_state", 32'(u_if.state), 4);
            chk("lw_dmem_req", 32'(u_if.dmem_req), 1);
            chk("lw_mem_wen", 32'(u_if.mem_wen), 0);
            chk("lw_reg_wen_wait", 32'(u_if.reg_wen), 0);
            cyc();
        end
        u_if.dmem_ready = 1'b1;
        #1;
        chk("lw_dmem_req_rdy", 32'(u_if.dmem_req), 1);
        chk("lw_pc_wen_mem", 32'(u_if.pc_wen), 0);
        cyc();
        u_if.dmem_ready = 1'b0;
        #1;
        chk("lw_wb", 32'(u_if.state), 6);
        chk("lw_reg_wen", 32'(u_if.reg_wen), 1);
        cyc();
        chk("lw_back_fetch", 32'(u_if.state), 1);
        chk("lw_reg_wen_off", 32'(u_if.reg_wen), 0);

        // SB with immediate dmem_ready
        do_fetch(I_SB, 0);
        cyc();
        chk("sb_exec_byte_mask", 32'(u_if.byte_mask), 3'b000);
        chk("sb_exec_reg_wen", 32'(u_if.reg_wen), 0);
        cyc();
        u_if.dmem_ready = 1'b1;
        #1;
        chk("sb_mem_state", 32'(u_if.state), 4);
        chk("sb_mem_wen", 32'(u_if.mem_wen), 1);
        chk("sb_pc_wen", 32'(u_if.pc_wen), 1);
        chk("sb_reg_wen", 32'(u_if.reg_wen), 0);
        cyc();
        u_if.dmem_ready = 1'b0;
        #1;
        chk("sb_back_fetch", 32'(u_if.state), 1);

        // BNE: pc_wen in EXEC, straight back to FETCH
        do_fetch(I_BNE, 0);
        cyc();
        chk("bne_exec", 32'(u_if.state), 3);
        chk("bne_branch_cond", 32'(u_if.branch_cond), 3'b001);
        chk("bne_pc_sel", 32'(u_if.alu_pc_sel), 1);
        chk("bne_imm_sel", 32'(u_if.alu_imm_sel), 1);
        chk("bne_pc_wen", 32'(u_if.pc_wen), 1);
        cyc();
        chk("bne_back_fetch", 32'(u_if.state), 1);

        // MUL with mdu_done after five cycles
        do_fetch(I_MUL, 0);
        cyc();
        chk("mul_mdu_state", 32'(u_if.state), 5);
        chk("mul_mdu_start", 32'(u_if.mdu_start), 1);
        chk("mul_mdu_op", 32'(u_if.mdu_op), 3'b000);
        chk("mul_wb_sel", 32'(u_if.wb_sel), 3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mul_wait_state", 32'(u_if.state), 5);
            chk("mul_start_once", 32'(u_if.mdu_start), 0);
        end
        cyc();
        u_if.mdu_done = 1'b1;
        #1;
        chk("mul_done_state", 32'(u_if.state), 5);
        cyc();
        u_if.mdu_done = 1'b0;
        #1;
        chk("mul_wb", 32'(u_if.state), 6);
        chk("mul_reg_wen", 32'(u_if.reg_wen), 1);
        cyc();
        chk("mul_back_fetch", 32'(u_if.state), 1);
        chk("mul_reg_wen_off", 32'(u_if.reg_wen), 0);

        // MUL with mdu_done on the entry cycle
        do_fetch(I_MUL, 0);
        cyc();
        u_if.mdu_done = 1'b1;
        #1;
        chk("mul0_start", 32'(u_if.mdu_start), 1);
        cyc();
        u_if.mdu_done = 1'b0;
        #1;
        chk("mul0_wb", 32'(u_if.state), 6);
        cyc();

        // Illegal opcode traps with cause 1 and stays there
        do_fetch(I_BAD, 0);
        cyc();
        chk("bad_state", 32'(u_if.state), 7);
        chk("bad_trap_cause", 32'(u_if.trap_cause), 1);
        chk("bad_illegal_op", 32'(u_if.illegal_op), 1);
        cyc();
        chk("bad_sticky", 32'(u_if.state), 7);
        chk("bad_imem_req", 32'(u_if.imem_req), 0);
        rst_n = 1'b0;
        #1;
        chk("bad_rst_state", 32'(u_if.state), 0);
        chk("bad_rst_cause", 32'(u_if.trap_cause), 0);
        chk("bad_rst_illegal", 32'(u_if.illegal_op), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("bad_rst_fetch", 32'(u_if.state), 1);

        // SB: ready on the expiry cycle wins over the timeout
        do_fetch(I_SB, 0);
        cyc();
        cyc();
        for (int i = 0; i < 14; i++) begin
            chk("edge_dmem_req", 32'(u_if.dmem_req), 1);
            cyc();
        end
        u_if.dmem_ready = 1'b1;
        #1;
        chk("edge_state", 32'(u_if.state), 4);
        chk("edge_pc_wen", 32'(u_if.pc_wen), 1);
        cyc();
        u_if.dmem_ready = 1'b0;
        #1;
        chk("edge_no_trap", 32'(u_if.state), 1);

        // LW: reset pulsed mid-MEM
        do_fetch(I_LW, 0);
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        chk("mid_mem_state", 32'(u_if.state), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(u_if.state), 0);
        chk("mid_rst_dmem_req", 32'(u_if.dmem_req), 0);
        chk("mid_rst_wb_sel", 32'(u_if.wb_sel), 0);
        chk("mid_rst_byte_mask", 32'(u_if.byte_mask), 3'b010);
        chk("mid_rst_imm_sel", 32'(u_if.alu_imm_sel), 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_idle", 32'(u_if.state), 0);
        cyc();
        chk("mid_rst_fetch", 32'(u_if.state), 1);

        // LW: dmem_ready stuck low -> bus trap after 15 waits
        do_fetch(I_LW, 0);
        cyc();
        cyc();
        for (int i = 0; i < 15; i++) begin
            chk("to_mem_state", 32'(u_if.state), 4);
            chk("to_dmem_req", 32'(u_if.dmem_req), 1);
            cyc();
        end
        chk("to_state", 32'(u_if.state), 7);
        chk("to_trap_cause", 32'(u_if.trap_cause), 2);
        chk("to_dmem_req_off", 32'(u_if.dmem_req), 0);
        chk("to_illegal_op", 32'(u_if.illegal_op), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
